alu_req_sequencer: RTL and testbench

- Initiator-side controller that owns the operand/opcode drive of the 16-bit combinational ALU (ops: clear, add, sub, mul, div) and returns its result through a handshake.
- Accepts one request at a time over valid/ready, registers operands onto the ALU inputs, and waits a per-op settle time, since mul/div are long combinational paths.
- Captures the ALU result into a one-entry response buffer and flags divide-by-zero and illegal opcodes without issuing them.

---
 rtl/alu_req_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_req_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_sequencer.sv
// Request sequencer for a 16-bit combinational ALU: accepts one request, drives the
// ALU operands for a per-op settle time, and buffers the result until it is consumed.
module alu_req_sequencer #(
  parameter int ADDSUB_WAIT = 1,
  parameter int MUL_WAIT    = 2,
  parameter int DIV_WAIT    = 4,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [2:0]  req_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_r,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;

  // The counter is loaded with wait-1 so that a response appears exactly N edges
  // after the accepting edge.
  localparam logic [CNT_W-1:0] ADDSUB_LOAD = CNT_W'(ADDSUB_WAIT - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD    = CNT_W'(MUL_WAIT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD    = CNT_W'(DIV_WAIT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      alu_a_q;
  logic [15:0]      alu_b_q;
  logic [2:0]       alu_op_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_data_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] load_cnt;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    load_cnt = ADDSUB_LOAD;
    case (req_op)
      OP_MUL:  load_cnt = MUL_LOAD;
      OP_DIV:  load_cnt = DIV_LOAD;
      default: load_cnt = ADDSUB_LOAD;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register sees the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_CLR;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            case (req_op)
              OP_ADD, OP_SUB, OP_MUL: begin
                alu_a_q  <= req_a;
                alu_b_q  <= req_b;
                alu_op_q <= req_op;
                cnt_q    <= load_cnt;
                state_q  <= S_WAIT;
              end
              OP_DIV: begin
                if (req_b == 16'h0000) begin
                  rsp_data_q  <= 16'hFFFF;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_HOLD;
                end else begin
                  alu_a_q  <= req_a;
                  alu_b_q  <= req_b;
                  alu_op_q <= req_op;
                  cnt_q    <= load_cnt;
                  state_q  <= S_WAIT;
                end
              end
              OP_CLR: begin
                rsp_data_q  <= 16'h0000;
                rsp_err_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
                state_q     <= S_HOLD;
              end
              default: begin
                rsp_data_q  <= 16'h0000;
                rsp_err_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
                state_q     <= S_HOLD;
              end
            endcase
          end
        end
        S_WAIT: begin
          // ALU inputs stay untouched here; only the settle counter moves.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            rsp_data_q  <= alu_r;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Self-checking bench for alu_req_sequencer: vector table plus hand sequences for
// reset-in-flight and back-to-back traffic, with a response scoreboard.
module tb_alu_req_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [2:0]  req_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_r;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  alu_req_sequencer #(
    .ADDSUB_WAIT(1),
    .MUL_WAIT   (2),
    .DIV_WAIT   (4),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_op   (req_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_r    (alu_r),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  // Combinational ALU the sequencer drives.
  always_comb begin
    alu_r = 16'h0000;
    case (alu_op)
      3'b001:  alu_r = alu_a + alu_b;
      3'b010:  alu_r = alu_a - alu_b;
      3'b011:  alu_r = alu_a * alu_b;
      3'b100:  alu_r = (alu_b == 16'h0000) ? 16'hFFFF : alu_a / alu_b;
      default: alu_r = 16'h0000;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_data;
    logic        exp_err;
    int          lat;
    bit          issue;
    int          hold;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pop   = 0;
  logic [16:0] sb_q[$];
  logic [15:0] last_a;
  logic [15:0] last_b;
  logic [2:0]  last_op;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: a handshake is about to happen on the next edge, compare it now.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got response %0h with nothing expected", rsp_data);
      end else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        check("sb_data", rsp_data, e[16:1]);
        check("sb_err", rsp_err, e[0]);
      end
      n_pop++;
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    check($sformatf("vec%0d ready", idx), req_ready, 1'b1);
    req_valid = 1'b1;
    req_a     = v.a;
    req_b     = v.b;
    req_op    = v.op;
    @(posedge clk);
    if (v.issue) begin
      last_a  = v.a;
      last_b  = v.b;
      last_op = v.op;
    end
    sb_q.push_back({v.exp_data, v.exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      check($sformatf("vec%0d alu_settle", idx), {alu_a, alu_b, alu_op}, {last_a, last_b, last_op});
      check($sformatf("vec%0d busy_wait", idx), busy, 1'b1);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check($sformatf("vec%0d latency", idx), lat, v.lat);
    check($sformatf("vec%0d data", idx), rsp_data, v.exp_data);
    check($sformatf("vec%0d err", idx), rsp_err, v.exp_err);
    check($sformatf("vec%0d alu", idx), {alu_a, alu_b, alu_op}, {last_a, last_b, last_op});
    for (int h = 0; h < v.hold; h++) begin
      // A competing request while holding must be ignored.
      req_valid = 1'b1;
      req_a     = 16'h0009;
      req_b     = 16'h0009;
      req_op    = 3'b011;
      @(negedge clk);
      check($sformatf("vec%0d hold_valid", idx), rsp_valid, 1'b1);
      check($sformatf("vec%0d hold_data", idx), {rsp_data, rsp_err}, {v.exp_data, v.exp_err});
      check($sformatf("vec%0d hold_ready", idx), req_ready, 1'b0);
      check($sformatf("vec%0d hold_busy", idx), busy, 1'b1);
      check($sformatf("vec%0d hold_alu", idx), {alu_a, alu_b, alu_op}, {last_a, last_b, last_op});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("vec%0d released", idx), {rsp_valid, req_ready, busy}, 3'b010);
    check($sformatf("vec%0d data_kept", idx), {rsp_data, rsp_err}, {v.exp_data, v.exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_acc;
    int          acc_cyc[2];
    int          pop0;
    bit          pending;
    bit          seen;

    //            op      a         b         data      err   lat iss hold
    vecs[0] = '{3'b001, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1, 1, 3};
    vecs[1] = '{3'b100, 16'd100,  16'd7,    16'd14,   1'b0, 4, 1, 0};
    vecs[2] = '{3'b100, 16'd5,    16'd0,    16'hFFFF, 1'b1, 0, 0, 0};
    vecs[3] = '{3'b110, 16'h1111, 16'h2222, 16'h0000, 1'b1, 0, 0, 0};
    vecs[4] = '{3'b000, 16'h3333, 16'h4444, 16'h0000, 1'b0, 0, 0, 0};
    vecs[5] = '{3'b010, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1, 1, 0};
    vecs[6] = '{3'b011, 16'h1234, 16'h0100, 16'h3400, 1'b0, 2, 1, 0};
    vecs[7] = '{3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1, 1, 0};
    vecs[8] = '{3'b101, 16'h0001, 16'h0001, 16'h0000, 1'b1, 0, 0, 0};
    vecs[9] = '{3'b100, 16'hFFFF, 16'h0002, 16'h7FFF, 1'b0, 4, 1, 0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    last_a    = '0;
    last_b    = '0;
    last_op   = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {rsp_valid, rsp_data, rsp_err, busy}, 19'd0);
    check("reset_alu", {alu_a, alu_b, alu_op}, 35'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", req_ready, 1'b1);

    // Reset in the middle of a divide settle: the response is dropped.
    req_valid = 1'b1;
    req_a     = 16'd100;
    req_b     = 16'd7;
    req_op    = 3'b100;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_issued", alu_op, 3'b100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_clear", {rsp_valid, busy, alu_a, alu_b, alu_op}, 37'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid_ready", req_ready, 1'b1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rstmid_no_rsp", seen, 1'b0);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Back-to-back: sub then mul, rsp_ready tied high, req_valid held high.
    rsp_ready = 1'b1;
    pop0      = n_pop;
    n_acc     = 0;
    pending   = 1'b0;
    acc_cyc[0] = -1;
    acc_cyc[1] = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 16'd10;
    req_b     = 16'd3;
    req_op    = 3'b010;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        if (n_acc == 1) begin
          req_a  = 16'd6;
          req_b  = 16'd7;
          req_op = 3'b011;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (req_valid && req_ready) begin
        if (n_acc < 2) acc_cyc[n_acc] = c;
        sb_q.push_back({(n_acc == 0) ? 16'd7 : 16'd42, 1'b0});
        n_acc++;
        pending = 1'b1;
      end
    end
    rsp_ready = 1'b0;
    check("b2b_accepts", n_acc, 2);
    check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 3);
    check("b2b_responses", n_pop - pop0, 2);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
